parallel2serial: RTL



---
 rtl/parallel2serial.sv | 89 ++++++++
 1 files changed

// File: rtl/parallel2serial.sv
// Parallel-to-serial transmitter: valid/ready word input, one bit per clock out,
// with a one-entry holding register so back-to-back words stream without a bubble.
module parallel2serial #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_parallel,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout_serial,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic load_slot;

    assign dout_valid  = (state_q == SHIFT);
    assign dout_last   = dout_valid && (cnt_q == LAST_CNT);
    assign dout_serial = dout_valid && (MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0]);
    assign busy        = dout_valid || hold_vld_q;
    assign din_ready   = !hold_vld_q && !rst;

    assign accept    = din_valid && din_ready;
    assign load_slot = !dout_valid || dout_last;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;

        if (!load_slot) begin
            sh_d  = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (accept) begin
                hold_d     = din_parallel;
                hold_vld_d = 1'b1;
            end
        end else if (hold_vld_q) begin
            // din_ready is low here, so no accept competes with the hold transfer
            sh_d       = hold_q;
            cnt_d      = '0;
            state_d    = SHIFT;
            hold_vld_d = 1'b0;
        end else if (accept) begin
            sh_d    = din_parallel;
            cnt_d   = '0;
            state_d = SHIFT;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

endmodule
